muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the Mini SRC datapath.
- Operands come from the bus (Y register and bus value). It produces a 2*WIDTH result that the control unit copies into HI/LO.
- Replaces single-cycle mul/div with a radix-2 iterative engine: signed and unsigned modes, start/done handshake, divide-by-zero flag.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: signed/unsigned MUL and DIV with a
// start/done handshake, a full 2*WIDTH result in hi/lo and a divide-by-zero flag.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, div_r;
  logic [2*WIDTH:0]   acc_r, step_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_r, rem_neg_r;

  logic               is_div_s, is_signed_s, a_sign_s, b_sign_s, div_zero_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     sum_s, trial_s;
  logic [2*WIDTH:0]   shift_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;

  // Next-state logic for the operation sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = PREP;
        else       state_s = IDLE;
      end
      PREP: begin
        if (div_zero_s) state_s = DONE;
        else            state_s = CALC;
      end
      CALC: begin
        if (cnt_r == CNT_W'(1)) state_s = FIX;
        else                    state_s = CALC;
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand conditioning, one iteration step and final sign fix-up.
  // The accumulator holds {upper W+1 bits, lower W bits}: for MUL the lower
  // half is the multiplier being shifted out, for DIV it is the dividend
  // being shifted into the partial remainder while quotient bits shift in.
  always_comb begin
    is_div_s    = op_r[1];
    is_signed_s = ~op_r[0];
    a_sign_s    = is_signed_s & a_r[WIDTH-1];
    b_sign_s    = is_signed_s & b_r[WIDTH-1];
    div_zero_s  = is_div_s & (b_r == {WIDTH{1'b0}});
    if (a_sign_s) mag_a_s = -a_r;
    else          mag_a_s = a_r;
    if (b_sign_s) mag_b_s = -b_r;
    else          mag_b_s = b_r;

    sum_s   = acc_r[2*WIDTH:WIDTH];
    shift_s = {acc_r[2*WIDTH-1:0], 1'b0};
    trial_s = shift_s[2*WIDTH:WIDTH] - {1'b0, div_r};
    if (is_div_s) begin
      if (shift_s[2*WIDTH:WIDTH] >= {1'b0, div_r}) step_s = {trial_s, shift_s[WIDTH-1:1], 1'b1};
      else                                         step_s = shift_s;
    end else begin
      if (acc_r[0]) sum_s = acc_r[2*WIDTH:WIDTH] + {1'b0, div_r};
      else          sum_s = acc_r[2*WIDTH:WIDTH];
      step_s = {1'b0, sum_s, acc_r[WIDTH-1:1]};
    end

    if (neg_r) prod_s = -acc_r[2*WIDTH-1:0];
    else       prod_s = acc_r[2*WIDTH-1:0];
    if (neg_r) quot_s = -acc_r[WIDTH-1:0];
    else       quot_s = acc_r[WIDTH-1:0];
    if (rem_neg_r) rem_s = -acc_r[2*WIDTH-1:WIDTH];
    else           rem_s = acc_r[2*WIDTH-1:WIDTH];
  end

  // State, handshake outputs and datapath registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
      dbz       <= 1'b0;
      op_r      <= 2'b00;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      div_r     <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH+1){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      neg_r     <= 1'b0;
      rem_neg_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == PREP) || (state_s == CALC) || (state_s == FIX);
      done    <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
            dbz  <= 1'b0;
          end
        end
        PREP: begin
          acc_r     <= {{(WIDTH+1){1'b0}}, mag_a_s};
          div_r     <= mag_b_s;
          cnt_r     <= CNT_W'(WIDTH);
          neg_r     <= a_sign_s ^ b_sign_s;
          rem_neg_r <= a_sign_s;
          if (div_zero_s) begin
            hi  <= a_r;
            lo  <= {WIDTH{1'b1}};
            dbz <= 1'b1;
          end
        end
        CALC: begin
          acc_r <= step_s;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        FIX: begin
          if (is_div_s) begin
            hi <= rem_s;
            lo <= quot_s;
          end else begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit instance for MUL/DIV/edge cases and
// an 8-bit instance for the narrow-width divide.
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int W8 = 8;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0, b = '0;
  logic [W-1:0]  hi, lo;
  logic          busy, done, dbz;
  logic          start8 = 1'b0;
  logic [1:0]    op8 = 2'b00;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic [W8-1:0] hi8, lo8;
  logic          busy8, done8, dbz8;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
  );

  muldiv_unit #(.WIDTH(W8)) dut8 (
    .clock(clock), .clear(clear), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbz(dbz8)
  );

  // Pulse start for one edge, scramble operands afterwards, and report the
  // number of edges after the accepting edge until done is seen (-1 on timeout).
  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     output int lat, output logic busy_acc, output logic dbz_acc);
    @(posedge clock); #1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    busy_acc = busy;
    dbz_acc  = dbz;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [W8-1:0] x, input logic [W8-1:0] y,
                      output int lat);
    @(posedge clock); #1;
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0; a8 = ~x; b8 = ~y;
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clock); #1;
      if (done8) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, dbz, hi, lo} !== {3'b000, 64'd0}) begin
      errors++;
      $display("FAIL reset32: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all zero", busy, done, dbz, hi, lo);
    end
    checks++;
    if ({busy8, done8, dbz8, hi8, lo8} !== {3'b000, 16'd0}) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all zero", busy8, done8, dbz8, hi8, lo8);
    end
    clear = 1'b1;
  endtask

  // Done is high during cycle k+W+3, i.e. right after the (W+2)th edge past acceptance.
  task automatic test_mul();
    int lat; logic ba, da;
    run(2'b00, 32'hFFFFFFFA, 32'd7, lat, ba, da);
    checks++;
    if (lat !== W + 2) begin errors++; $display("FAIL mul_latency: got %0d expected %0d", lat, W + 2); end
    checks++;
    if (ba !== 1'b1) begin errors++; $display("FAIL mul_busy_after_start: got %b expected 1", ba); end
    checks++;
    if ({busy, hi, lo} !== {1'b0, 32'hFFFFFFFF, 32'hFFFFFFD6}) begin
      errors++; $display("FAIL mul_result: got busy=%b hi=%h lo=%h expected busy=0 hi=ffffffff lo=ffffffd6", busy, hi, lo);
    end
    @(posedge clock); #1;
    checks++;
    if ({done, hi, lo} !== {1'b0, 32'hFFFFFFFF, 32'hFFFFFFD6}) begin
      errors++; $display("FAIL mul_hold: got done=%b hi=%h lo=%h expected done=0 hi=ffffffff lo=ffffffd6", done, hi, lo);
    end
  endtask

  task automatic test_mulu();
    int lat; logic ba, da;
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, ba, da);
    checks++;
    if ({hi, lo} !== {32'hFFFFFFFE, 32'h00000001} || lat !== W + 2) begin
      errors++; $display("FAIL mulu: got hi=%h lo=%h lat=%0d expected hi=fffffffe lo=00000001 lat=%0d", hi, lo, lat, W + 2);
    end
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, ba, da);
    checks++;
    if ({hi, lo} !== {32'h00000000, 32'h00000001}) begin
      errors++; $display("FAIL mul_minus1_sq: got hi=%h lo=%h expected hi=00000000 lo=00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] va [3] = '{32'd100, 32'hFFFFFF9C, 32'h80000000};
    logic [W-1:0] vb [3] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF};
    logic [W-1:0] eq [3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h80000000};
    logic [W-1:0] er [3] = '{32'd2, 32'hFFFFFFFE, 32'd0};
    int lat; logic ba, da;
    for (int i = 0; i < 3; i++) begin
      run(2'b10, va[i], vb[i], lat, ba, da);
      checks++;
      if ({lo, hi, dbz} !== {eq[i], er[i], 1'b0} || lat !== W + 2) begin
        errors++;
        $display("FAIL div_%0d: got lo=%h hi=%h dbz=%b lat=%0d expected lo=%h hi=%h dbz=0 lat=%0d",
                 i, lo, hi, dbz, lat, eq[i], er[i], W + 2);
      end
    end
  endtask

  task automatic test_dbz();
    int lat; logic ba, da;
    run(2'b10, 32'h12345678, 32'd0, lat, ba, da);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
    checks++;
    if ({dbz, hi, lo, busy} !== {1'b1, 32'h12345678, 32'hFFFFFFFF, 1'b0}) begin
      errors++; $display("FAIL dbz_result: got dbz=%b hi=%h lo=%h busy=%b expected dbz=1 hi=12345678 lo=ffffffff busy=0", dbz, hi, lo, busy);
    end
    run(2'b11, 32'd9, 32'd2, lat, ba, da);
    checks++;
    if (da !== 1'b0) begin errors++; $display("FAIL dbz_clear: got dbz=%b after accept expected 0", da); end
    checks++;
    if ({lo, hi, dbz} !== {32'd4, 32'd1, 1'b0} || lat !== W + 2) begin
      errors++; $display("FAIL divu: got lo=%h hi=%h dbz=%b lat=%0d expected lo=4 hi=1 dbz=0 lat=%0d", lo, hi, dbz, lat, W + 2);
    end
  endtask

  task automatic test_start_ignored();
    int pulses = 0;
    @(posedge clock); #1;
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(posedge clock); #1;
      if (done) begin
        pulses++;
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL start_held_pulses: got %0d expected 1", pulses); end
    checks++;
    if ({hi, lo} !== {32'd0, 32'd15}) begin
      errors++; $display("FAIL start_held_result: got hi=%h lo=%h expected hi=0 lo=f", hi, lo);
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    @(posedge clock); #1;
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2 clear = 1'b0;
    #1;
    checks++;
    if ({busy, done, dbz, hi, lo} !== {3'b000, 64'd0}) begin
      errors++; $display("FAIL abort_clear: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all zero", busy, done, dbz, hi, lo);
    end
    @(posedge clock); #1;
    clear = 1'b1;
    for (int n = 0; n < W + 10; n++) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: got pulses=%0d busy=%b expected pulses=0 busy=0", pulses, busy);
    end
  endtask

  task automatic test_width8();
    int lat;
    run8(2'b10, 8'h81, 8'h0A, lat);
    checks++;
    if (lat !== W8 + 2) begin errors++; $display("FAIL w8_latency: got %0d expected %0d", lat, W8 + 2); end
    checks++;
    if ({lo8, hi8, dbz8} !== {8'hF4, 8'hF9, 1'b0}) begin
      errors++; $display("FAIL w8_div: got lo=%h hi=%h dbz=%b expected lo=f4 hi=f9 dbz=0", lo8, hi8, dbz8);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulu();
    test_div();
    test_dbz();
    test_start_ignored();
    test_abort();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
